lcd_show_bitmap: RTL and testbench
==================================

Name: lcd_show_bitmap

Overview:
- Parametrised successor to the full-screen monochrome picture renderer.
- Draws a 1-bit-per-pixel bitmap of IMG_W x IMG_H from a row-wide ROM into a placeable LCD window at (x0, y0).
- Foreground and background RGB565 colours are set at run time.
- Sits between the top-level display sequencer and the LCD write engine, and emits 9-bit {dc, byte} words over a wr_done handshake.

Parameters:
- IMG_W, 240, bitmap width in pixels; also the rom_q width.
- IMG_H, 320, bitmap height in rows; also the ROM depth.
- ROW_AW, 9, ROM address width; must satisfy 2^ROW_AW >= IMG_H.
- LCD_XMAX, 239, last valid LCD column.
- LCD_YMAX, 319, last valid LCD row.
- ROM_LAT, 2, ROM read latency in cycles, from address to valid rom_q.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; latches x0, y0, fg, bg.
- abort  in  1  one-cycle cancel of the current draw.
- x0  in  9  window left column.
- y0  in  9  window top row.
- fg_color  in  16  RGB565 colour for bitmap bit 1.
- bg_color  in  16  RGB565 colour for bitmap bit 0.
- rom_addr  out  ROW_AW  bitmap row address.
- rom_q  in  IMG_W  bitmap row; bit 0 is the leftmost pixel.
- wr_done  in  1  writer consumed the current word.
- out_data  out  9  bit 8 = 1 for data, 0 for command; bits 7:0 = byte.
- out_valid  out  1  out_data is valid and must be written.
- busy  out  1  a draw is in progress.
- done  out  1  one-cycle pulse when a draw completes.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Interface decision (already decided): one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; out_data 9'h000; out_valid, busy, done, err all 0; rom_addr 0.
- Window bounds: xe = x0 + W - 1, ye = y0 + H - 1, where W = IMG_W and H = IMG_H (doubled under the optional feature). Compute in 10 bits to avoid wrap.
- Start rejection: if xe > LCD_XMAX or ye > LCD_YMAX, pulse err for one cycle and stay in IDLE.
- start while busy is ignored.
- FSM states: IDLE, SET_WIN, FETCH, PIXEL, DONE.
  - IDLE -> SET_WIN on an accepted start.
  - SET_WIN sends 11 words in this order:
    - 9'h02A, then {1, x0[15:8]}, {1, x0[7:0]}, {1, xe[15:8]}, {1, xe[7:0]}, with coordinates zero-extended to 16 bits.
    - 9'h02B, then y0 and ye in the same hi/lo form.
    - 9'h02C.
  - SET_WIN -> FETCH after wr_done on the 11th word.
  - FETCH: drive rom_addr = row, wait ROM_LAT cycles, load rom_q into the shift register, -> PIXEL. out_valid is 0 throughout FETCH.
  - PIXEL: each pixel is two words, hi byte then lo byte, of fg_color if the current bit is 1, else bg_color. The shift register moves right by 1 on wr_done of the lo byte.
  - After the lo byte of pixel IMG_W-1: if row < IMG_H-1, increment row and go to FETCH; otherwise go to DONE.
  - DONE: done = 1 for exactly one cycle, busy drops, then -> IDLE.
- Handshake:
  - out_valid is registered.
  - The next word appears in the cycle after wr_done.
  - out_data is held stable while out_valid = 1 and wr_done = 0.
  - wr_done while out_valid = 0 is ignored.
- Abort takes effect in the next cycle from any state: -> IDLE, out_valid = 0, no done pulse, counters cleared. Abort wins over a simultaneous wr_done or start.
- Totals: the full image is exactly 11 + 2*W*H accepted words. Every row is drawn, including the last.
- busy = 1 in every state except IDLE.

Optional Feature:
- Macro: LCD_BMP_SCALE2_EN.
- Defined: each source bit is emitted as 2 adjacent pixels (4 words), and each ROM row is drawn twice. Window size is 2*IMG_W x 2*IMG_H, and the bounds check uses the doubled size. Re-use the latched row; only one FETCH per source row is required.
- Undefined: 1:1 output. Scale logic is absent.

Decomposition:
- Package lcd_pkg holds:
  - command constants CMD_CASET 8'h2A, CMD_RASET 8'h2B, CMD_RAMWR 8'h2C;
  - colour constants WHITE 16'hFFFF and BLACK 16'h0000;
  - the state enum;
  - DC_CMD = 0 and DC_DATA = 1.
- One sub-module, lcd_win_cmd_seq: takes x0/xe/y0/ye and produces the 11-word SET_WIN sequence with its own wr_done counter and a finish pulse.

Test Plan (IMG_W = 8, IMG_H = 4, ROM_LAT = 2; writer returns wr_done 1–3 cycles after out_valid, randomised):
- Basic draw: start, x0 = 10, y0 = 20, fg = F800, bg = 001F, ROM rows 8'h01, 8'h80, 8'hFF, 8'h00 -> command stream 02A, 100, 10A, 100, 111, 02B, 100, 114, 100, 117, 02C. Then 64 data words; row 0 begins 1F8, 100 (fg), then 7 bg pixels as 100, 11F each. done pulses exactly once.
- Bounds reject: x0 = 233 (xe = 240) -> err pulses for one cycle, out_valid never rises, busy stays 0. x0 = 232 is accepted.
- Back-pressure: hold wr_done low for 50 cycles mid-pixel -> out_data and out_valid remain unchanged; total accepted words = 75.
- Abort: abort during row 2 PIXEL -> out_valid = 0 next cycle, no done. An immediate new start redraws correctly from the 02A command.
- Ignored start and simultaneous events: start while busy -> no effect. abort together with wr_done -> IDLE, and the word count does not increment.
- Scaled mode (LCD_BMP_SCALE2_EN defined), x0 = 0, y0 = 0 -> xe = 15, ye = 7; 11 + 256 words; each ROM row address is issued once.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants, FSM state type and word-building helpers
//               for the LCD bitmap renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // LCD controller commands
    localparam logic [7:0]  CMD_CASET = 8'h2A;
    localparam logic [7:0]  CMD_RASET = 8'h2B;
    localparam logic [7:0]  CMD_RAMWR = 8'h2C;

    // Convenience RGB565 colours
    localparam logic [15:0] WHITE     = 16'hFFFF;
    localparam logic [15:0] BLACK     = 16'h0000;

    // Data/command flag carried in bit 8 of every output word
    localparam logic        DC_CMD    = 1'b0;
    localparam logic        DC_DATA   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET_WIN = 3'd1,
        S_FETCH   = 3'd2,
        S_PIXEL   = 3'd3,
        S_DONE    = 3'd4
    } lcd_state_t;

    function automatic logic [8:0] dc_word(input logic dc, input logic [7:0] b);
        return {dc, b};
    endfunction

    // One byte of an RGB565 colour as a data word; lo_sel picks the low byte
    function automatic logic [8:0] rgb_byte_word(input logic [15:0] color, input logic lo_sel);
        return dc_word(DC_DATA, lo_sel ? color[7:0] : color[15:8]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_win_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : lcd_win_cmd_seq
// Description : Produces the 11-word window set-up sequence
//               (CASET x0 xe, RASET y0 ye, RAMWR). o_word is the word that
//               must be loaded into the output register on this cycle's
//               launch/step, so the top can register it without extra delay.
// Ports       : clk, rst       - clock, async active-high reset
//               i_clear        - drop the sequence (abort)
//               i_launch       - begin a new sequence (word 0 on o_word)
//               i_step         - current word was accepted by the writer
//               i_x0..i_ye     - window bounds, 10 bits
//               o_word         - next word to present
//               o_finish       - last word accepted
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_win_cmd_seq
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_launch,
    input  logic       i_step,
    input  logic [9:0] i_x0,
    input  logic [9:0] i_xe,
    input  logic [9:0] i_y0,
    input  logic [9:0] i_ye,
    output logic [8:0] o_word,
    output logic       o_finish
);

    localparam logic [3:0] c_LAST_IDX = 4'd10;

    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;

    // Index of the word that becomes visible after this cycle
    assign w_idx_nxt = i_launch ? 4'd0 : (r_idx + 4'd1);
    assign o_finish  = i_step && (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 4'd0;
        end else if (i_clear || i_launch || o_finish) begin
            r_idx <= 4'd0;
        end else if (i_step) begin
            r_idx <= w_idx_nxt;
        end
    end

    // Coordinates are zero-extended to 16 bits: high byte holds bits 9:8
    always_comb begin
        o_word = dc_word(DC_CMD, CMD_CASET);
        case (w_idx_nxt)
            4'd0:    o_word = dc_word(DC_CMD,  CMD_CASET);
            4'd1:    o_word = dc_word(DC_DATA, {6'd0, i_x0[9:8]});
            4'd2:    o_word = dc_word(DC_DATA, i_x0[7:0]);
            4'd3:    o_word = dc_word(DC_DATA, {6'd0, i_xe[9:8]});
            4'd4:    o_word = dc_word(DC_DATA, i_xe[7:0]);
            4'd5:    o_word = dc_word(DC_CMD,  CMD_RASET);
            4'd6:    o_word = dc_word(DC_DATA, {6'd0, i_y0[9:8]});
            4'd7:    o_word = dc_word(DC_DATA, i_y0[7:0]);
            4'd8:    o_word = dc_word(DC_DATA, {6'd0, i_ye[9:8]});
            4'd9:    o_word = dc_word(DC_DATA, i_ye[7:0]);
            4'd10:   o_word = dc_word(DC_CMD,  CMD_RAMWR);
            default: o_word = dc_word(DC_CMD,  CMD_CASET);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lcd_show_bitmap.sv
`default_nettype none
// ============================================================================
// Module      : lcd_show_bitmap
// Description : Draws an IMG_W x IMG_H 1-bpp bitmap from a row-wide ROM into
//               an LCD window at (x0, y0) using run-time fg/bg RGB565 colours.
//               Emits 9-bit {dc, byte} words over a wr_done handshake.
//               Optional macro LCD_BMP_SCALE2_EN doubles every pixel and row.
// Ports       : sys_clk, sys_rst          - clock, async active-high reset
//               start, abort              - one-cycle request / cancel
//               x0, y0, fg_color, bg_color- window origin and colours
//               rom_addr, rom_q           - bitmap row ROM (bit 0 = leftmost)
//               wr_done                   - writer consumed out_data
//               out_data, out_valid       - {dc, byte} word and its valid
//               busy, done, err           - status / pulses
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_show_bitmap
    import lcd_pkg::*;
#(
    parameter int IMG_W    = 240,
    parameter int IMG_H    = 320,
    parameter int ROW_AW   = 9,
    parameter int LCD_XMAX = 239,
    parameter int LCD_YMAX = 319,
    parameter int ROM_LAT  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [8:0]        x0,
    input  logic [8:0]        y0,
    input  logic [15:0]       fg_color,
    input  logic [15:0]       bg_color,
    output logic [ROW_AW-1:0] rom_addr,
    input  logic [IMG_W-1:0]  rom_q,
    input  logic              wr_done,
    output logic [8:0]        out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef LCD_BMP_SCALE2_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int         PIX_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int         LAT_W    = $clog2(ROM_LAT + 2);
    localparam logic [9:0] c_WIN_WM1 = 10'(IMG_W * SCALE - 1);
    localparam logic [9:0] c_WIN_HM1 = 10'(IMG_H * SCALE - 1);

    lcd_state_t        r_state, w_state_nxt;
    logic [9:0]        r_x0, r_xe, r_y0, r_ye;
    logic [15:0]       r_fg, r_bg;
    logic [ROW_AW-1:0] r_row;
    logic [LAT_W-1:0]  r_lat;
    logic [IMG_W-1:0]  r_shift;
    logic [PIX_W-1:0]  r_pix;
    logic [1:0]        r_phase;
    logic [8:0]        r_out_data;
    logic              r_out_valid, r_busy, r_done, r_err;

    logic [9:0]        w_xe, w_ye;
    logic              w_oob, w_idle, w_accept, w_reject, w_ack;
    logic              w_seq_step, w_seq_finish;
    logic              w_lat_hit, w_pix_last, w_ph_last, w_row_last, w_row_end, w_line_last;
    logic [8:0]        w_seq_word;

    // Bounds computed in 10 bits so x0 + W - 1 cannot wrap
    assign w_xe       = {1'b0, x0} + c_WIN_WM1;
    assign w_ye       = {1'b0, y0} + c_WIN_HM1;
    assign w_oob      = (w_xe > 10'(LCD_XMAX)) || (w_ye > 10'(LCD_YMAX));
    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = w_idle && start && !abort && !w_oob;
    assign w_reject   = w_idle && start && !abort && w_oob;
    // Abort beats a simultaneous wr_done: the word is not consumed
    assign w_ack      = r_out_valid && wr_done && !abort;
    assign w_seq_step = (r_state == S_SET_WIN) && w_ack;
    assign w_lat_hit  = (r_lat == LAT_W'(ROM_LAT));
    assign w_pix_last = (r_pix == PIX_W'(IMG_W - 1));
    assign w_ph_last  = (r_phase == 2'(2 * SCALE - 1));
    assign w_row_last = (r_row == ROW_AW'(IMG_H - 1));
    assign w_row_end  = (r_state == S_PIXEL) && w_ack && w_ph_last && w_pix_last;

`ifdef LCD_BMP_SCALE2_EN
    logic             r_line;     // second pass over the same source row
    logic [IMG_W-1:0] r_row_buf;  // source row kept for the repeat pass
    assign w_line_last = r_line;
`else
    assign w_line_last = 1'b1;
`endif

    lcd_win_cmd_seq u_win_seq (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_clear  (abort),
        .i_launch (w_accept),
        .i_step   (w_seq_step),
        .i_x0     (r_x0),
        .i_xe     (r_xe),
        .i_y0     (r_y0),
        .i_ye     (r_ye),
        .o_word   (w_seq_word),
        .o_finish (w_seq_finish)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)     w_state_nxt = S_SET_WIN;
            S_SET_WIN: if (w_seq_finish) w_state_nxt = S_FETCH;
            S_FETCH:   if (w_lat_hit)    w_state_nxt = S_PIXEL;
            S_PIXEL:   if (w_row_end && w_line_last)
                           w_state_nxt = w_row_last ? S_DONE : S_FETCH;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_err   <= w_reject;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_x0 <= '0; r_xe <= '0; r_y0 <= '0; r_ye <= '0;
            r_fg <= '0; r_bg <= '0;
            r_row <= '0; r_lat <= '0; r_shift <= '0; r_pix <= '0; r_phase <= '0;
            r_out_data  <= 9'h000;
            r_out_valid <= 1'b0;
`ifdef LCD_BMP_SCALE2_EN
            r_line    <= 1'b0;
            r_row_buf <= '0;
`endif
        end else if (abort) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 9'h000;
            r_row <= '0; r_lat <= '0; r_pix <= '0; r_phase <= '0;
`ifdef LCD_BMP_SCALE2_EN
            r_line <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_x0 <= {1'b0, x0}; r_xe <= w_xe;
                    r_y0 <= {1'b0, y0}; r_ye <= w_ye;
                    r_fg <= fg_color;   r_bg <= bg_color;
                    r_row <= '0; r_pix <= '0; r_phase <= '0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_seq_word;
                end
                S_SET_WIN: if (w_ack) begin
                    if (w_seq_finish) begin
                        r_out_valid <= 1'b0;
                        r_lat       <= '0;
                    end else begin
                        r_out_data  <= w_seq_word;
                    end
                end
                S_FETCH: begin
                    r_lat <= r_lat + 1'b1;
                    if (w_lat_hit) begin
                        r_shift     <= rom_q;
                        r_pix       <= '0;
                        r_phase     <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= rgb_byte_word(rom_q[0] ? r_fg : r_bg, 1'b0);
`ifdef LCD_BMP_SCALE2_EN
                        r_row_buf   <= rom_q;
`endif
                    end
                end
                S_PIXEL: if (w_ack) begin
                    if (!w_ph_last) begin
                        // Phases alternate hi/lo; the next phase is lo when this one is even
                        r_phase    <= r_phase + 1'b1;
                        r_out_data <= rgb_byte_word(r_shift[0] ? r_fg : r_bg, ~r_phase[0]);
                    end else if (!w_pix_last) begin
                        r_phase    <= '0;
                        r_pix      <= r_pix + 1'b1;
                        r_shift    <= r_shift >> 1;
                        r_out_data <= rgb_byte_word(r_shift[1] ? r_fg : r_bg, 1'b0);
                    end
`ifdef LCD_BMP_SCALE2_EN
                    else if (!r_line) begin
                        // Redraw the held row without another ROM fetch
                        r_line     <= 1'b1;
                        r_phase    <= '0;
                        r_pix      <= '0;
                        r_shift    <= r_row_buf;
                        r_out_data <= rgb_byte_word(r_row_buf[0] ? r_fg : r_bg, 1'b0);
                    end
`endif
                    else begin
                        r_out_valid <= 1'b0;
                        r_lat       <= '0;
                        r_phase     <= '0;
                        r_pix       <= '0;
`ifdef LCD_BMP_SCALE2_EN
                        r_line      <= 1'b0;
`endif
                        if (!w_row_last) begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr  = r_row;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_show_bitmap.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_show_bitmap
// Description : Self-checking bench for lcd_show_bitmap (8x4 bitmap, ROM
//               latency 2). Expected word streams come from a reference
//               model that walks the bitmap rows/columns directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_show_bitmap;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int LAT = 2;
`ifdef LCD_BMP_SCALE2_EN
    localparam int SC  = 2;
`else
    localparam int SC  = 1;
`endif
    localparam int NWORDS = 11 + 2 * W * H * SC * SC;

    logic         sys_clk = 1'b0;
    logic         sys_rst, start, abort, wr_done;
    logic [8:0]   x0, y0;
    logic [15:0]  fg_color, bg_color;
    logic [1:0]   rom_addr;
    logic [W-1:0] rom_q;
    logic [8:0]   out_data;
    logic         out_valid, busy, done, err;

    logic [W-1:0] mem [H];
    logic [W-1:0] rom_pipe [LAT];
    logic [8:0]   got [$];
    logic [8:0]   exp_q [$];
    logic [8:0]   basic_ref [15];

    int total = 0, bad = 0, n_done = 0, n_err = 0, wcnt = 0;
    bit hold = 0, chk_on = 0, saw_valid = 0;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        rom_pipe[0] <= mem[rom_addr];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[LAT-1];

    lcd_show_bitmap #(
        .IMG_W(W), .IMG_H(H), .ROW_AW(2),
        .LCD_XMAX(239), .LCD_YMAX(319), .ROM_LAT(LAT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .fg_color(fg_color), .bg_color(bg_color),
        .rom_addr(rom_addr), .rom_q(rom_q), .wr_done(wr_done),
        .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference stream: window commands, then every row (repeated SC times)
    // and every column (repeated SC times) as hi/lo colour bytes.
    task automatic build_exp(input int x, input int y, input logic [15:0] f, input logic [15:0] b);
        logic [15:0] xs, xe, ys, ye, c;
        xs = 16'(x); xe = 16'(x + W * SC - 1);
        ys = 16'(y); ye = 16'(y + H * SC - 1);
        exp_q.delete();
        exp_q.push_back(9'h02A);
        exp_q.push_back({1'b1, xs[15:8]}); exp_q.push_back({1'b1, xs[7:0]});
        exp_q.push_back({1'b1, xe[15:8]}); exp_q.push_back({1'b1, xe[7:0]});
        exp_q.push_back(9'h02B);
        exp_q.push_back({1'b1, ys[15:8]}); exp_q.push_back({1'b1, ys[7:0]});
        exp_q.push_back({1'b1, ye[15:8]}); exp_q.push_back({1'b1, ye[7:0]});
        exp_q.push_back(9'h02C);
        for (int r = 0; r < H; r++)
            for (int rr = 0; rr < SC; rr++)
                for (int col = 0; col < W; col++)
                    for (int k = 0; k < SC; k++) begin
                        c = mem[r][col] ? f : b;
                        exp_q.push_back({1'b1, c[15:8]});
                        exp_q.push_back({1'b1, c[7:0]});
                    end
    endtask

    // One clock: record accepted words, check the presented word against
    // the model, then decide the writer's wr_done for the next edge.
    task automatic tick();
        logic p_valid, p_wr, p_abort;
        logic [8:0] p_data;
        p_valid = out_valid; p_wr = wr_done; p_abort = abort; p_data = out_data;
        @(posedge sys_clk); #1;
        if (p_valid && p_wr && !p_abort) got.push_back(p_data);
        n_done += int'(done);
        n_err  += int'(err);
        if (out_valid) saw_valid = 1;
        if (chk_on && out_valid) begin
            if (got.size() < exp_q.size()) chk("word", 32'(out_data), 32'(exp_q[got.size()]));
            else chk("extra_word_valid", 32'(out_valid), 32'd0);
        end
        if (hold || !out_valid) begin
            wr_done = 1'b0; wcnt = 0;
        end else begin
            if (wcnt == 0) wcnt = $urandom_range(1, 3);
            wcnt--;
            wr_done = (wcnt == 0);
        end
    endtask

    task automatic pulse_start(input int x, input int y, input logic [15:0] f, input logic [15:0] b);
        x0 = 9'(x); y0 = 9'(y); fg_color = f; bg_color = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_words(input int n, input string tag);
        int k = 0;
        while (got.size() < n && k < 3000) begin tick(); k++; end
        chk({tag, "_reach"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k = 0;
        while (n_done == d0 && k < 3000) begin tick(); k++; end
        tick(); tick();
        chk({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_words"}, 32'(got.size()), 32'(NWORDS));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic rand_rom();
        for (int r = 0; r < H; r++) mem[r] = W'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, n0;
        logic [15:0] f, b;
        basic_ref = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h111, 9'h02B, 9'h100, 9'h114,
                      9'h100, 9'h117, 9'h02C, 9'h1F8, 9'h100, 9'h100, 9'h11F};
        sys_rst = 1'b1; start = 1'b0; abort = 1'b0; wr_done = 1'b0;
        x0 = '0; y0 = '0; fg_color = '0; bg_color = '0;
        for (int r = 0; r < H; r++) mem[r] = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_out_data",  32'(out_data),  32'h000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_rom_addr",  32'(rom_addr),  32'd0);
        sys_rst = 1'b0;
        tick();

        // Basic draw
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF; mem[3] = 8'h00;
        build_exp(10, 20, 16'hF800, 16'h001F);
        got.delete(); chk_on = 1; d0 = n_done;
        pulse_start(10, 20, 16'hF800, 16'h001F);
        chk("basic_busy", 32'(busy), 32'd1);
        wait_done(d0, "basic");
`ifndef LCD_BMP_SCALE2_EN
        for (int i = 0; i < 15; i++) chk("basic_lit", 32'(got[i]), 32'(basic_ref[i]));
`endif

        // Bounds rejects (x then y), one past the last fitting origin
        chk_on = 0;
        saw_valid = 0; e0 = n_err;
        pulse_start(239 - W * SC + 2, 0, 16'h1234, 16'h5678);
        repeat (5) tick();
        chk("rejx_err_cnt", 32'(n_err - e0), 32'd1);
        chk("rejx_no_valid", 32'(saw_valid), 32'd0);
        chk("rejx_busy", 32'(busy), 32'd0);
        e0 = n_err;
        pulse_start(0, 319 - H * SC + 2, 16'h1234, 16'h5678);
        repeat (5) tick();
        chk("rejy_err_cnt", 32'(n_err - e0), 32'd1);
        chk("rejy_no_valid", 32'(saw_valid), 32'd0);

        // Last fitting column, random image, 50-cycle writer stall mid-row
        rand_rom(); f = 16'($urandom); b = 16'($urandom);
        build_exp(239 - W * SC + 1, 5, f, b);
        got.delete(); chk_on = 1; d0 = n_done; e0 = n_err;
        pulse_start(239 - W * SC + 1, 5, f, b);
        chk("edge_no_err", 32'(n_err - e0), 32'd0);
        wait_words(20, "bp");
        hold = 1;
        tick();
        n0 = got.size();
        chk("bp_valid_pre", 32'(out_valid), 32'd1);
        repeat (50) tick();
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_data_held", 32'(out_data), 32'(exp_q[n0]));
        chk("bp_no_accept", 32'(got.size()), 32'(n0));
        hold = 0;
        wait_done(d0, "bp");

        // Start while busy (out-of-range coords) must be ignored
        rand_rom(); f = 16'($urandom); b = 16'($urandom);
        build_exp(3, 7, f, b);
        got.delete(); d0 = n_done; e0 = n_err;
        pulse_start(3, 7, f, b);
        wait_words(15, "ign");
        pulse_start(400, 300, ~f, ~b);
        chk("ign_no_err", 32'(n_err - e0), 32'd0);
        wait_done(d0, "ign");

        // Abort in row 2 together with wr_done, then immediate redraw
        rand_rom(); f = 16'($urandom); b = 16'($urandom);
        build_exp(50, 60, f, b);
        got.delete(); d0 = n_done;
        pulse_start(50, 60, f, b);
        wait_words(11 + 2 * W * SC * SC * 2 + 3, "abort");
        hold = 1;
        tick();
        chk("abort_pre_valid", 32'(out_valid), 32'd1);
        chk_on = 0;
        abort = 1'b1; wr_done = 1'b1;
        tick();
        abort = 1'b0; wr_done = 1'b0; hold = 0;
        chk("abort_valid_low", 32'(out_valid), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        rand_rom(); f = 16'($urandom); b = 16'($urandom);
        build_exp(100, 200, f, b);
        got.delete(); chk_on = 1;
        pulse_start(100, 200, f, b);
        wait_done(d0, "redraw");

`ifdef LCD_BMP_SCALE2_EN
        // Scaled window at the origin: xe = 15, ye = 7
        rand_rom(); f = 16'($urandom); b = 16'($urandom);
        build_exp(0, 0, f, b);
        got.delete(); d0 = n_done;
        pulse_start(0, 0, f, b);
        wait_done(d0, "scale");
        chk("scale_xe_lo", 32'(got[4]), 32'h10F);
        chk("scale_ye_lo", 32'(got[9]), 32'h107);
`endif

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
